// File: rtl/mp_adder_pkg.sv
// Shared types and helpers for the multi-precision limb-serial adder.
package mp_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Limb counter width; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned limbs);
        return (limbs > 1) ? $clog2(limbs) : 1;
    endfunction

endpackage

// File: rtl/mp_adder_limb.sv
// One limb of the ripple chain: {co, s} = a + b + ci, unsigned.
module mp_adder_limb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    assign {co, s} = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(ci);

endmodule

// File: rtl/mp_adder.sv
// Limb-serial multi-precision adder, LS limb first, with carry chained across limbs.
// Optional subtract mode (A + ~B + 1) enabled by defining MP_ADDER_SUB_EN.
module mp_adder
    import mp_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMBS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cin,
`ifdef MP_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             cout,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned    CW       = cnt_w(LIMBS);
    localparam logic [CW-1:0]  LAST_IDX = CW'(LIMBS - 1);

    state_t            state_q, state_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              zacc_q, zacc_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_sum_q, out_sum_d;
    logic              out_last_q, out_last_d;
    logic              cout_q, cout_d;
    logic              zero_q, zero_d;

    logic              xfer_c;
    logic              last_xfer_c;
    logic              start_carry_c;
    logic [WIDTH-1:0]  b_eff_c;
    logic [WIDTH-1:0]  limb_s_c;
    logic              limb_co_c;

`ifdef MP_ADDER_SUB_EN
    logic              sub_q, sub_d;
    assign b_eff_c       = sub_q ? ~in_b : in_b;
    assign start_carry_c = sub ? 1'b1 : cin;
`else
    assign b_eff_c       = in_b;
    assign start_carry_c = cin;
`endif

    assign in_ready    = (state_q == RUN) && (!out_valid_q || out_ready);
    assign xfer_c      = in_valid && in_ready;
    assign last_xfer_c = xfer_c && (cnt_q == LAST_IDX);

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign busy      = (state_q != IDLE);

    mp_adder_limb #(.WIDTH(WIDTH)) u_limb (
        .a  (in_a),
        .b  (b_eff_c),
        .ci (carry_q),
        .s  (limb_s_c),
        .co (limb_co_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)                    state_d = RUN;
            RUN:     if (last_xfer_c)              state_d = DRAIN;
            DRAIN:   if (out_valid_q && out_ready) state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    // Datapath next values: operation setup, limb transfer, result hand-off
    always_comb begin
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        zacc_d      = zacc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
`ifdef MP_ADDER_SUB_EN
        sub_d       = sub_q;
`endif
        if ((state_q == IDLE) && start) begin
            carry_d = start_carry_c;
            cnt_d   = '0;
            zacc_d  = 1'b1;
`ifdef MP_ADDER_SUB_EN
            sub_d   = sub;
`endif
        end
        if (xfer_c) begin
            carry_d     = limb_co_c;
            cnt_d       = last_xfer_c ? cnt_q : cnt_q + CW'(1);
            zacc_d      = zacc_q && (limb_s_c == '0);
            out_valid_d = 1'b1;
            out_sum_d   = limb_s_c;
            out_last_d  = last_xfer_c;
            cout_d      = limb_co_c;
            zero_d      = zacc_q && (limb_s_c == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            zacc_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            zacc_q      <= zacc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
        end
    end

`ifdef MP_ADDER_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sub_q <= 1'b0;
        else        sub_q <= sub_d;
    end
`endif

endmodule

// File: tb/tb_mp_adder.sv
// Self-checking bench for mp_adder: whole-operand reference sums, directed and random traffic.
module tb_mp_adder;

    localparam int unsigned W = 8;
    localparam int unsigned L = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cin;
`ifdef MP_ADDER_SUB_EN
    logic         sub_s;
`endif
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_last;
    logic         cout;
    logic         zero;
    logic         busy;

    int    passed = 0;
    int    total  = 0;
    string cur    = "init";

    mp_adder #(.WIDTH(W), .LIMBS(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cin       (cin),
`ifdef MP_ADDER_SUB_EN
        .sub       (sub_s),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .cout      (cout),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s/%s: observed %0h expected %0h", cur, tag, obs, exp);
    endtask

    // mode 0: random valid/ready; 1: ready held low 3 cycles after 1st limb; 2: start pulse mid-run
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input int mode);
        logic [32:0]  full;
        logic         eov, eir;
        int           li, lo, cyc, held;
        bit           pulsed;
        cur  = name;
        full = s ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b} + 33'(c));
        start = 1'b1; cin = c; in_valid = 1'b0; out_ready = 1'b0;
`ifdef MP_ADDER_SUB_EN
        sub_s = s;
`endif
        @(negedge clk);
        start = 1'b0;
        li = 0; lo = 0; cyc = 0; held = 0; pulsed = 0;
        while (lo < L && cyc < 200) begin
            eov   = (li > lo);
            start = 1'b0;
            case (mode)
                1: begin
                    in_valid = 1'b1;
                    if (lo == 0 && eov && held < 3) begin out_ready = 1'b0; held++; end
                    else out_ready = 1'b1;
                end
                2: begin
                    in_valid  = 1'b1;
                    out_ready = 1'b1;
                    if (li == 2 && !pulsed) begin start = 1'b1; cin = ~c; pulsed = 1; end
                end
                default: begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            endcase
            in_a = (li < L) ? a[li*W +: W] : W'($urandom);
            in_b = (li < L) ? b[li*W +: W] : W'($urandom);
            #1;
            eir = (li < L) && (!eov || out_ready);
            chk("in_ready", 32'(in_ready), 32'(eir));
            chk("out_valid", 32'(out_valid), 32'(eov));
            chk("busy", 32'(busy), 32'd1);
            if (eov) begin
                chk($sformatf("out_sum[%0d]", lo), 32'(out_sum), 32'(full[lo*W +: W]));
                chk($sformatf("out_last[%0d]", lo), 32'(out_last), 32'(lo == L - 1));
                if (lo == L - 1) begin
                    chk("cout", 32'(cout), 32'(full[32]));
                    chk("zero", 32'(zero), 32'(full[31:0] == 32'd0));
                end
            end
            if (eov && out_ready)  lo++;
            if (in_valid && eir)   li++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (cyc >= 200) chk("timeout_limbs_out", 32'(lo), 32'(L));
        #1;
        chk("busy_after", 32'(busy), 32'd0);
        chk("out_valid_after", 32'(out_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
`ifdef MP_ADDER_SUB_EN
        sub_s = 1'b0;
`endif
        #3;
        cur = "reset";
        chk("in_ready", 32'(in_ready), 32'd0);
        chk("out_valid", 32'(out_valid), 32'd0);
        chk("out_sum", 32'(out_sum), 32'd0);
        chk("out_last", 32'(out_last), 32'd0);
        chk("cout", 32'(cout), 32'd0);
        chk("zero", 32'(zero), 32'd0);
        chk("busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("ff_plus_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("wrap_b1",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("wrap_cin",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op("all_zero",    32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
        run_op("stall3",      32'h89AB_CDEF, 32'h7654_3211, 1'b1, 1'b0, 1);
        run_op("start_pulse", 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 2);

        // Asynchronous reset with a carry pending after two limbs
        cur = "rst_mid";
        start = 1'b1; cin = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01;
        @(negedge clk);
        in_a = 8'hFF; in_b = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("out_valid", 32'(out_valid), 32'd0);
        chk("out_sum", 32'(out_sum), 32'd0);
        chk("out_last", 32'(out_last), 32'd0);
        chk("cout", 32'(cout), 32'd0);
        chk("zero", 32'(zero), 32'd0);
        chk("busy", 32'(busy), 32'd0);
        chk("in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);

`ifdef MP_ADDER_SUB_EN
        run_op("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
        run_op("sub_eq",     32'h0000_ABCD, 32'h0000_ABCD, 1'b1, 1'b1, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 4 == 3) ? ~ra : $urandom;
            run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mp_adder.md
MP_ADDER -- requirements
Module: mp_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning limb width in bits (>=2).
REQ-002 SHALL have parameter LIMBS, default 4, meaning limbs per operand (>=2); operand width = WIDTH*LIMBS.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begins an operation; accepted only in IDLE.
REQ-006 SHALL have port cin  input  1  carry-in, sampled with an accepted start.
REQ-007 SHALL have port in_valid  input  1  in_a/in_b hold a valid limb.
REQ-008 SHALL have port in_ready  output  1  block accepts a limb this cycle.
REQ-009 SHALL have port in_a  input  WIDTH  operand A limb, least-significant limb first.
REQ-010 SHALL have port in_b  input  WIDTH  operand B limb, same order.
REQ-011 SHALL have port out_valid  output  1  out_sum holds a valid result limb.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result limb.
REQ-013 SHALL have port out_sum  output  WIDTH  result limb, least-significant first.
REQ-014 SHALL have port out_last  output  1  out_sum is the final limb.
REQ-015 SHALL have port cout  output  1  carry out of the final limb; meaningful when out_valid&&out_last.
REQ-016 SHALL have port zero  output  1  whole result is zero; meaningful when out_valid&&out_last.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-019 IDLE->RUN SHALL occur on start=1; the carry register loads cin, the limb counter and zero accumulator clear.
REQ-020 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-021 A limb transfer SHALL occur when in_valid && in_ready; {carry,out_sum} <= in_a + in_b + carry, registered, so out_valid rises one cycle after the transfer.
REQ-022 The carry register SHALL take the limb carry-out on every transfer and chain it into the next limb.
REQ-023 zero SHALL be the AND over all transferred limbs of (sum limb == 0).
REQ-024 out_last SHALL be set on the limb transferred with counter == LIMBS-1; cout and zero SHALL be valid with it and held until it is consumed.
REQ-025 RUN->DRAIN SHALL occur on transfer of limb LIMBS-1; DRAIN->IDLE SHALL occur when out_valid && out_ready.
REQ-026 out_valid SHALL clear when out_ready=1 and no new transfer occurs that cycle; while out_valid && !out_ready, out_sum/out_last/cout/zero SHALL remain stable.
REQ-027 start SHALL be ignored in RUN and DRAIN; in_valid SHALL be ignored in IDLE and DRAIN.
REQ-028 Arithmetic SHALL be unsigned modulo 2^WIDTH per limb; the limb counter SHALL be $clog2(LIMBS) bits and never wrap mid-operation.

Reset
REQ-029 On rst_n=0, at any time including mid-operation, state SHALL go to IDLE, and out_valid, out_sum, out_last, cout, zero, busy, in_ready, carry and counter SHALL be 0 without waiting for clk.
REQ-030 The first operation after reset release SHALL be unaffected by any partially processed operation.

Configuration
REQ-031 With macro MP_ADDER_SUB_EN defined, an input port sub (1 bit, sampled with start) SHALL exist; sub=1 SHALL compute A-B as A+~B+1 (cin ignored), cout=1 meaning no borrow.
REQ-032 Without MP_ADDER_SUB_EN the port sub SHALL not exist and only addition with cin SHALL be performed.

Structure
REQ-033 State enum and helper function for counter width SHALL reside in package mp_adder_pkg.
REQ-034 The per-limb combinational adder SHALL be sub-module mp_adder_limb (a, b, ci -> s, co, WIDTH parameter).

Verification (WIDTH=8, LIMBS=4)
REQ-035 cin=0, A=0x000000FF, B=0x00000001 -> out_sum 00,01,00,00, out_last on 4th, cout=0, zero=0.
REQ-036 cin=0, A=0xFFFFFFFF, B=0x00000001 -> out_sum 00,00,00,00, cout=1, zero=1; cin=1 with A=0xFFFFFFFF, B=0 gives the same.
REQ-037 out_ready held 0 for 3 cycles after the 1st limb -> in_ready=0, out_sum stable at its value, no limb lost, final result correct.
REQ-038 start pulsed during RUN -> ignored, result identical to the undisturbed run; busy=1 from start until the last limb is consumed.
REQ-039 rst_n asserted asynchronously after 2 limbs -> all outputs 0 immediately, IDLE; the next operation with A=0x12345678, B=0x11111111 yields 89,67,45,23, cout=0.
REQ-040 With MP_ADDER_SUB_EN, sub=1, A=0x00000005, B=0x00000007 -> FE,FF,FF,FF, cout=0, zero=0; A=B=0x0000ABCD -> zero=1, cout=1.
